// File: rtl/scs8hd_a22o_arb2_if.sv
// Bus bundle for the two-source a22o arbiter: requests and data in, grants and merged result out.
// The master side drives requests and data; the slave side is the arbiter.
interface scs8hd_a22o_arb2_if #(
    parameter int WIDTH = 1
) ();
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] x;
    logic             busy;

    modport master (
        output req0, req1, d0, d1,
        input  gnt0, gnt1, x, busy
    );

    modport slave (
        input  req0, req1, d0, d1,
        output gnt0, gnt1, x, busy
    );
endinterface

// File: rtl/scs8hd_a22o_arb2.sv
// Round-robin arbiter owning the two AND-term enables of an a22o merge, with a bounded hold
// time, and a registered X = (gnt0 & d0) | (gnt1 & d1) computed from the registered grants.
module scs8hd_a22o_arb2 #(
    parameter int WIDTH   = 1,
    parameter int MAXHOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    scs8hd_a22o_arb2_if.slave    bus
`ifdef SC_USE_PG_PIN
    ,
    input  logic                 vpwr,
    input  logic                 vgnd,
    input  logic                 vpb,
    input  logic                 vnb
`endif
);

`ifndef SC_USE_PG_PIN
    supply1 vpwr;
    supply0 vgnd;
    supply1 vpb;
    supply0 vnb;
`endif

    localparam logic [7:0] HOLD_LIM = 8'(MAXHOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_r;
    logic             gnt0_r;
    logic             gnt1_r;
    logic             busy_r;
    logic             last_r;
    logic [7:0]       hcnt_r;
    logic [WIDTH-1:0] x_r;
    logic             pwr_good_s;
    logic             arst_s;

    function automatic logic [WIDTH-1:0] and_or(
        input logic             g0,
        input logic             g1,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        return ({WIDTH{g0}} & a) | ({WIDTH{g1}} & b);
    endfunction

    // A missing supply holds the block in reset, just like the RESET pin.
    assign pwr_good_s = vpwr & vpb & ~vgnd & ~vnb;
    assign arst_s     = rst | ~pwr_good_s;

    // Ownership FSM, hold counter, last-owner flag and the merged data register.
    always_ff @(posedge clk or posedge arst_s) begin
        if (arst_s) begin
            state_r <= IDLE;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            busy_r  <= 1'b0;
            last_r  <= 1'b1;
            hcnt_r  <= 8'd0;
            x_r     <= {WIDTH{1'b0}};
        end else begin
            x_r <= and_or(gnt0_r, gnt1_r, bus.d0, bus.d1);
            case (state_r)
                IDLE: begin
                    // last_r = 1 means source 1 owned last, so source 0 wins a tie.
                    if (bus.req0 && (!bus.req1 || last_r)) begin
                        state_r <= OWN0;
                        gnt0_r  <= 1'b1;
                        gnt1_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        hcnt_r  <= 8'd1;
                        last_r  <= 1'b0;
                    end else if (bus.req1) begin
                        state_r <= OWN1;
                        gnt0_r  <= 1'b0;
                        gnt1_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        hcnt_r  <= 8'd1;
                        last_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                OWN0: begin
                    if (!bus.req0) begin
                        if (bus.req1) begin
                            state_r <= OWN1;
                            gnt0_r  <= 1'b0;
                            gnt1_r  <= 1'b1;
                            busy_r  <= 1'b1;
                            hcnt_r  <= 8'd1;
                            last_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            gnt0_r  <= 1'b0;
                            gnt1_r  <= 1'b0;
                            busy_r  <= 1'b0;
                        end
                    end else if (hcnt_r < HOLD_LIM) begin
                        hcnt_r <= hcnt_r + 8'd1;
                    end else if (bus.req1) begin
                        state_r <= OWN1;
                        gnt0_r  <= 1'b0;
                        gnt1_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        hcnt_r  <= 8'd1;
                        last_r  <= 1'b1;
                    end else begin
                        hcnt_r <= HOLD_LIM;
                    end
                end
                OWN1: begin
                    if (!bus.req1) begin
                        if (bus.req0) begin
                            state_r <= OWN0;
                            gnt0_r  <= 1'b1;
                            gnt1_r  <= 1'b0;
                            busy_r  <= 1'b1;
                            hcnt_r  <= 8'd1;
                            last_r  <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            gnt0_r  <= 1'b0;
                            gnt1_r  <= 1'b0;
                            busy_r  <= 1'b0;
                        end
                    end else if (hcnt_r < HOLD_LIM) begin
                        hcnt_r <= hcnt_r + 8'd1;
                    end else if (bus.req0) begin
                        state_r <= OWN0;
                        gnt0_r  <= 1'b1;
                        gnt1_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        hcnt_r  <= 8'd1;
                        last_r  <= 1'b0;
                    end else begin
                        hcnt_r <= HOLD_LIM;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt0_r  <= 1'b0;
                    gnt1_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0 = gnt0_r;
    assign bus.gnt1 = gnt1_r;
    assign bus.busy = busy_r;
    assign bus.x    = x_r;

endmodule
